// File: rtl/led_rr_arbiter.sv
// Round-robin arbiter granting one of four request lines a shared display slot for a bounded hold time.
// Define LED_ARB_LOCK_EN to let btn[1] freeze the hold timer of the current grant.
module led_rr_arbiter #(
    parameter logic [31:0] HOLD_CYCLES = 32'd5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic [7:0]  sw,
    output logic [15:0] ledr
);

    // state   | meaning
    // S_IDLE  | no grant, waiting for any request
    // S_GRANT | one index owns the slot, hold timer counting
    // S_GAP   | single dead cycle between grants
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [31:0] HOLD_LAST = HOLD_CYCLES - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic [3:0]  onehot_q, onehot_d;
    logic        lock_q, lock_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [3:0] req;
    logic       soft_clr;
    logic       lock_req;
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       unused_inputs;

    assign req      = sw[3:0];
    assign soft_clr = btn[0];

`ifdef LED_ARB_LOCK_EN
    assign lock_req      = btn[1];
    assign unused_inputs = ^{btn[4:2], sw[7:4]};
`else
    assign lock_req      = 1'b0;
    assign unused_inputs = ^{btn[4:1], sw[7:4]};
`endif

    // Search starts one past the last winner; i=4 wraps back onto last itself.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        last_d   = last_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        onehot_d = onehot_q;
        lock_d   = lock_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE, S_GAP: begin
                valid_d  = 1'b0;
                onehot_d = 4'b0000;
                lock_d   = 1'b0;
                state_d  = S_IDLE;
                if (win_found) begin
                    state_d  = S_GRANT;
                    idx_d    = win_idx;
                    last_d   = win_idx;
                    valid_d  = 1'b1;
                    onehot_d = 4'b0001 << win_idx;
                    hold_d   = 32'd0;
                    cnt_d    = cnt_q + 8'd1;
                end
            end
            S_GRANT: begin
                // A dropped request always releases; lock only masks timer expiry.
                if (!req[idx_q] || (!lock_req && hold_q == HOLD_LAST)) begin
                    state_d  = S_GAP;
                    valid_d  = 1'b0;
                    onehot_d = 4'b0000;
                    lock_d   = 1'b0;
                end else if (lock_req) begin
                    lock_d = 1'b1;
                end else begin
                    lock_d = 1'b0;
                    hold_d = hold_q + 32'd1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                valid_d  = 1'b0;
                onehot_d = 4'b0000;
                lock_d   = 1'b0;
            end
        endcase

        if (soft_clr) begin
            state_d  = S_IDLE;
            hold_d   = 32'd0;
            last_d   = 2'd3;
            idx_d    = 2'd0;
            valid_d  = 1'b0;
            onehot_d = 4'b0000;
            lock_d   = 1'b0;
            cnt_d    = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hold_q   <= 32'd0;
            last_q   <= 2'd3;
            idx_q    <= 2'd0;
            valid_q  <= 1'b0;
            onehot_q <= 4'b0000;
            lock_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
            lock_q   <= lock_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ledr = {cnt_q, onehot_q, lock_q, valid_q, idx_q};

endmodule

// File: tb/tb_led_rr_arbiter.sv
// Scenario bench for led_rr_arbiter with HOLD_CYCLES=4; expected grants are queued as stimulus is applied.
module tb_led_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [4:0]  btn;
    logic [7:0]  sw;
    logic [15:0] ledr;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

`ifdef LED_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    led_rr_arbiter #(.HOLD_CYCLES(32'd4)) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .sw   (sw),
        .ledr (ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        btn = 5'b00000;
        sw  = 8'h0F;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (ledr !== 16'h0000) begin
                failures++;
                $display("FAIL reset_hold n=%0d got=%h exp=0000", n, ledr);
            end
        end
        sw  = 8'h00;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ledr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=0000", ledr);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic exp_v;
        sw = 8'h0F;
        for (int k = 0; k < 5; k++) exp_q.push_back('{idx: 2'(k), cnt: 8'(k + 1)});
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            exp_v = ((n - 1) % 5) != 4;
            checks++;
            if (ledr[2] !== exp_v || (!exp_v && ledr[7:4] !== 4'b0000)) begin
                failures++;
                $display("FAIL rr_valid n=%0d got=%h exp_valid=%b", n, ledr, exp_v);
            end
            if ((n - 1) % 5 == 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rr_queue n=%0d got=%h exp=<entry>", n, ledr);
                end else begin
                    e = exp_q.pop_front();
                    if (ledr[1:0] !== e.idx || ledr[7:4] !== (4'b0001 << e.idx) || ledr[15:8] !== e.cnt) begin
                        failures++;
                        $display("FAIL rr_grant n=%0d got=%h exp_idx=%0d exp_cnt=%0d", n, ledr, e.idx, e.cnt);
                    end
                end
            end
        end
        checks++;
        if (ledr[15:8] !== 8'd5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rr_count got=%0d exp=5 left=%0d", ledr[15:8], exp_q.size());
        end
        sw = 8'h00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_early_release();
        exp_t e;
        btn = 5'b00001;
        sw  = 8'h00;
        @(negedge clk);
        btn = 5'b00000;
        sw  = 8'h02;
        exp_q.push_back('{idx: 2'd1, cnt: 8'd1});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (ledr[2] !== 1'b1 || ledr[1:0] !== e.idx || ledr[7:4] !== 4'b0010 || ledr[15:8] !== e.cnt) begin
            failures++;
            $display("FAIL er_grant got=%h exp_idx=%0d exp_oh=0010 exp_cnt=%0d", ledr, e.idx, e.cnt);
        end
        @(negedge clk);
        checks++;
        if (ledr[2] !== 1'b1) begin
            failures++;
            $display("FAIL er_second got=%h exp_valid=1", ledr);
        end
        sw = 8'h00;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (ledr !== 16'h0101) begin
                failures++;
                $display("FAIL er_gap_idle n=%0d got=%h exp=0101", n, ledr);
            end
        end
    endtask

    task automatic test_sole_requester();
        exp_t e;
        logic exp_v;
        btn = 5'b00001;
        sw  = 8'h00;
        @(negedge clk);
        btn = 5'b00000;
        sw  = 8'h04;
        for (int k = 0; k < 3; k++) exp_q.push_back('{idx: 2'd2, cnt: 8'(k + 1)});
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            exp_v = ((n - 1) % 5) != 4;
            checks++;
            if (ledr[2] !== exp_v) begin
                failures++;
                $display("FAIL sole_valid n=%0d got=%h exp_valid=%b", n, ledr, exp_v);
            end
            if ((n - 1) % 5 == 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sole_queue n=%0d got=%h exp=<entry>", n, ledr);
                end else begin
                    e = exp_q.pop_front();
                    if (ledr[1:0] !== e.idx || ledr[7:4] !== 4'b0100 || ledr[15:8] !== e.cnt) begin
                        failures++;
                        $display("FAIL sole_grant n=%0d got=%h exp_idx=%0d exp_cnt=%0d", n, ledr, e.idx, e.cnt);
                    end
                end
            end
        end
        sw = 8'h00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_ignored_inputs();
        exp_t e;
        btn = 5'b00001;
        sw  = 8'h00;
        @(negedge clk);
        btn = 5'b00000;
        sw  = 8'h01;
        exp_q.push_back('{idx: 2'd0, cnt: 8'd1});
        exp_q.push_back('{idx: 2'd1, cnt: 8'd2});
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            checks++;
            if (n <= 4 && (ledr[2] !== 1'b1 || ledr[1:0] !== 2'd0 || ledr[3] !== 1'b0)) begin
                failures++;
                $display("FAIL ign_hold n=%0d got=%h exp_idx=0 exp_valid=1", n, ledr);
            end else if (n == 5 && ledr[2] !== 1'b0) begin
                failures++;
                $display("FAIL ign_gap got=%h exp_valid=0", ledr);
            end
            if (n == 1 || n == 6) begin
                e = exp_q.pop_front();
                checks++;
                if (ledr[1:0] !== e.idx || ledr[15:8] !== e.cnt || ledr[2] !== 1'b1) begin
                    failures++;
                    $display("FAIL ign_grant n=%0d got=%h exp_idx=%0d exp_cnt=%0d", n, ledr, e.idx, e.cnt);
                end
            end
            if (n == 1) begin
                sw  = 8'hF3;
                btn = 5'b11100;
            end
        end
        btn = 5'b00000;
        sw  = 8'h00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_lock();
        exp_t e;
        int   vend;
        logic exp_v;
        logic exp_l;
        vend = LOCK_EN ? 14 : 4;
        btn = 5'b00001;
        sw  = 8'h00;
        @(negedge clk);
        btn = 5'b00000;
        sw  = 8'h03;
        exp_q.push_back('{idx: 2'd0, cnt: 8'd1});
        exp_q.push_back('{idx: 2'd1, cnt: 8'd2});
        for (int n = 1; n <= vend + 2; n++) begin
            @(negedge clk);
            exp_v = (n <= vend) || (n == vend + 2);
            exp_l = LOCK_EN && n >= 2 && n <= 11;
            checks++;
            if (ledr[2] !== exp_v || ledr[3] !== exp_l) begin
                failures++;
                $display("FAIL lock_cycle n=%0d got=%h exp_valid=%b exp_lock=%b", n, ledr, exp_v, exp_l);
            end
            if (n == 1 || n == vend + 2) begin
                e = exp_q.pop_front();
                checks++;
                if (ledr[1:0] !== e.idx || ledr[15:8] !== e.cnt) begin
                    failures++;
                    $display("FAIL lock_grant n=%0d got=%h exp_idx=%0d exp_cnt=%0d", n, ledr, e.idx, e.cnt);
                end
            end
            if (n == 1) btn = 5'b00010;
            if (n == 11) btn = 5'b00000;
        end
        btn = 5'b00000;
        sw  = 8'h00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_clear();
        exp_t e;
        logic exp_v;
        btn = 5'b00001;
        sw  = 8'h00;
        @(negedge clk);
        btn = 5'b00000;
        sw  = 8'h0F;
        for (int k = 0; k < 3; k++) exp_q.push_back('{idx: 2'(k), cnt: 8'(k + 1)});
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            exp_v = ((n - 1) % 5) != 4;
            checks++;
            if (ledr[2] !== exp_v) begin
                failures++;
                $display("FAIL clr_valid n=%0d got=%h exp_valid=%b", n, ledr, exp_v);
            end
            if ((n - 1) % 5 == 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ledr[1:0] !== e.idx || ledr[15:8] !== e.cnt) begin
                    failures++;
                    $display("FAIL clr_grant n=%0d got=%h exp_idx=%0d exp_cnt=%0d", n, ledr, e.idx, e.cnt);
                end
            end
        end
        btn = 5'b00001;
        @(negedge clk);
        checks++;
        if (ledr !== 16'h0000) begin
            failures++;
            $display("FAIL clr_outputs got=%h exp=0000", ledr);
        end
        btn = 5'b00000;
        exp_q.push_back('{idx: 2'd0, cnt: 8'd1});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (ledr[2] !== 1'b1 || ledr[1:0] !== e.idx || ledr[15:8] !== e.cnt) begin
            failures++;
            $display("FAIL clr_regrant got=%h exp_idx=%0d exp_cnt=%0d", ledr, e.idx, e.cnt);
        end
        sw = 8'h00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_midgrant();
        exp_t e;
        sw = 8'h0F;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ledr[2] !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre got=%h exp_valid=1", ledr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ledr !== 16'h0000) begin
            failures++;
            $display("FAIL rst_async got=%h exp=0000", ledr);
        end
        @(negedge clk);
        checks++;
        if (ledr !== 16'h0000) begin
            failures++;
            $display("FAIL rst_held got=%h exp=0000", ledr);
        end
        rst = 1'b0;
        exp_q.push_back('{idx: 2'd0, cnt: 8'd1});
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (ledr[2] !== 1'b1 || ledr[1:0] !== e.idx || ledr[7:4] !== 4'b0001 || ledr[15:8] !== e.cnt) begin
            failures++;
            $display("FAIL rst_first got=%h exp_idx=%0d exp_cnt=%0d", ledr, e.idx, e.cnt);
        end
        sw = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_early_release();
        test_sole_requester();
        test_ignored_inputs();
        test_lock();
        test_clear();
        test_reset_midgrant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_rr_arbiter.md
LED_RR_ARBITER -- requirements
Module: led_rr_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 5000000, giving the grant hold time in clk cycles (legal range 1..2^32-1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port btn, input, 5 bits: btn[0] is a synchronous soft clear, btn[1] is the lock request, and btn[4:2] are ignored.
REQ-005 The block SHALL have port sw, input, 8 bits: sw[3:0] are request lines req[3:0], and sw[7:4] are ignored.
REQ-006 The block SHALL have port ledr, output, 16 bits: [1:0] granted index, [2] grant valid, [3] lock active, [7:4] one-hot grant, [15:8] grant counter.

Function
REQ-007 The block SHALL arbitrate req[3:0] for one shared display slot using a round-robin policy.
REQ-008 The block SHALL search from index (last+1) mod 4 upward with wrap, where "last" is the most recently granted index.
REQ-009 The block SHALL implement exactly three states: IDLE, GRANT and GAP.
REQ-010 In IDLE with any req high, the block SHALL enter GRANT on the next edge with ledr[2]=1, ledr[1:0]=winner, ledr[7:4]=1<<winner, last=winner and hold counter=0 (1-cycle latency).
REQ-011 In IDLE with req=0, the block SHALL stay in IDLE with ledr[2]=0 and ledr[7:4]=0; ledr[1:0] SHALL keep the previous index.
REQ-012 In GRANT, the hold counter SHALL increment by 1 each cycle.
REQ-013 In GRANT, the block SHALL enter GAP when the counter reaches HOLD_CYCLES-1 or when req[granted] is low.
REQ-014 When the release condition and the counter expiry occur in the same cycle, the block SHALL treat it as a single release into GAP.
REQ-015 GAP SHALL last exactly 1 cycle with ledr[2]=0 and ledr[7:4]=0; the block SHALL then arbitrate as in IDLE, or go to IDLE if req=0.
REQ-016 If only the previous winner is still requesting at the end of GAP, the block SHALL re-grant that same index.
REQ-017 The grant counter ledr[15:8] SHALL increment by 1 on every entry to GRANT, wrapping from 255 to 0.
REQ-018 Soft clear (btn[0]=1 at an edge) SHALL force IDLE, clear the hold counter, grant outputs and grant counter, and set last=3; it SHALL take priority over all other transitions, including lock.
REQ-019 Outputs SHALL be registered with no combinational path from sw or btn to ledr.
REQ-020 A change of requests other than the granted index SHALL have no effect during GRANT.

Reset
REQ-021 While rst=1, the block SHALL hold: state=IDLE, hold counter=0, last=3, and ledr=16'h0000.
REQ-022 Reset asserted mid-GRANT or mid-GAP SHALL abort the operation immediately (asynchronously) with no completion of the current grant.
REQ-023 After rst deasserts, the first arbitration SHALL start the search at index 0.

Configuration
REQ-024 Macro LED_ARB_LOCK_EN SHALL control the lock feature.
REQ-025 With LED_ARB_LOCK_EN defined and btn[1]=1 in GRANT, the hold counter SHALL freeze, expiry SHALL be suppressed and ledr[3]=1.
REQ-026 With LED_ARB_LOCK_EN defined, lock SHALL NOT suppress release when req[granted] drops.
REQ-027 With LED_ARB_LOCK_EN defined, when btn[1] drops the counter SHALL resume from its frozen value.
REQ-028 Without LED_ARB_LOCK_EN, btn[1] SHALL be ignored and ledr[3] SHALL be constant 0.

Verification
REQ-029 Round robin (HOLD_CYCLES=4, sw=8'h0F after reset): grants SHALL follow 0,1,2,3,0; each SHALL have ledr[2]=1 for 4 cycles, separated by 1 GAP cycle; ledr[15:8] SHALL read 5 after the fifth grant.
REQ-030 Early release (HOLD_CYCLES=4, sw=8'h02): ledr[1:0]=1 and ledr[7:4]=4'b0010 one cycle later; sw set to 0 in the second GRANT cycle SHALL produce GAP, then IDLE, with ledr[2]=0.
REQ-031 Sole requester (HOLD_CYCLES=4, sw=8'h04 held): the block SHALL grant index 2 repeatedly as a 4-cycle GRANT plus 1-cycle GAP pattern, with the counter incrementing each time.
REQ-032 Lock (macro defined, HOLD_CYCLES=4, sw=8'h03): btn[1]=1 for 10 cycles during grant 0 SHALL keep index 0 granted with ledr[3]=1; after btn[1] drops, the remaining cycles SHALL complete, then index 1 SHALL be granted.
REQ-033 Reset and clear: rst pulsed mid-GRANT SHALL make ledr=16'h0000 within the same cycle; btn[0] pulsed after 3 grants SHALL make ledr[15:8]=0, and the next grant SHALL be index 0.
